// File: rtl/ad7476a_sample_scheduler.sv
// ad7476a_sample_scheduler
//   Paces conversions of an ad7476a_interface at a programmable period, in
//   continuous or fixed-length burst mode, and presents the captured samples
//   on a valid/ready stream.
//
//   Optional feature macro: SAMPLE_TIMESTAMP_EN
//     defined   : free-running TS_WIDTH counter; its value at each request is
//                 delivered on m_ts_o together with the matching sample
//     undefined : no counter, m_ts_o tied to 0
//
//   Ports
//     clk_i, rst_ni            clock, async active-low reset
//     start_i, abort_i         control pulses
//     mode_i                   0 continuous, 1 burst
//     period_i, burst_len_i    configuration, latched on start_i
//     adc_request_o            one-cycle conversion request to the interface
//     adc_data_i/_valid_i      conversion result from the interface
//     m_valid_o/m_ready_i      output stream handshake
//     m_data_o, m_ts_o         held sample and its request timestamp
//     busy_o, done_o           sequencing status
//     late_o, overrun_o        sticky error flags, cleared on start_i
module ad7476a_sample_scheduler #(
  parameter int NUM_DEVICES    = 1,
  parameter int PERIOD_WIDTH   = 16,
  parameter int BURST_WIDTH    = 8,
  parameter int STARTUP_CYCLES = 4,
  parameter int TS_WIDTH       = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic                      mode_i,
  input  logic [PERIOD_WIDTH-1:0]   period_i,
  input  logic [BURST_WIDTH-1:0]    burst_len_i,
  output logic                      adc_request_o,
  input  logic [12*NUM_DEVICES-1:0] adc_data_i,
  input  logic                      adc_data_valid_i,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [12*NUM_DEVICES-1:0] m_data_o,
  output logic [TS_WIDTH-1:0]       m_ts_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      late_o,
  output logic                      overrun_o
);
  localparam int SU_N = (STARTUP_CYCLES < 1) ? 1 : STARTUP_CYCLES;
  localparam int SCW  = (SU_N > 1) ? $clog2(SU_N) : 1;
  localparam int BCW  = BURST_WIDTH + 1;

  typedef enum logic [1:0] {ST_STARTUP, ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic                    done_d;
  logic [SCW-1:0]          su_cnt_q;
  logic                    mode_q;
  logic [PERIOD_WIDTH-1:0] period_q, per_cnt_q;
  logic [BCW-1:0]          burst_q, smp_cnt_q;
  logic                    pending_q, inflight_q;

  logic su_done, launch, tick, capture, burst_end, can_load;

  assign su_done   = (su_cnt_q == SCW'(SU_N - 1));
  assign launch    = (state_q == ST_IDLE) && start_i && !abort_i;
  assign tick      = (state_q == ST_RUN) && (per_cnt_q == '0);
  assign capture   = adc_data_valid_i && inflight_q;
  assign burst_end = capture && mode_q && ((smp_cnt_q + BCW'(1)) == burst_q);
  assign can_load  = !m_valid_o || m_ready_i;

  // Gating on !adc_data_valid_i keeps the request out of the interface's
  // strobe cycle; gating on !abort_i keeps an aborting cycle from starting
  // a conversion that nobody would wait for.
  assign adc_request_o = (state_q == ST_RUN) && pending_q && !inflight_q &&
                         !adc_data_valid_i && !abort_i;

  // STARTUP is not reported as busy so that every output reads 0 in reset.
  assign busy_o = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_STARTUP;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_STARTUP: if (su_done) state_d = ST_IDLE;
      ST_IDLE:    if (launch)  state_d = ST_RUN;
      ST_RUN: begin
        if (abort_i) begin
          // A result arriving in the abort cycle is captured now, so there
          // is nothing left to drain.
          if (inflight_q && !adc_data_valid_i) state_d = ST_DRAIN;
          else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else if (burst_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (adc_data_valid_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      su_cnt_q   <= '0;
      mode_q     <= 1'b0;
      period_q   <= '0;
      per_cnt_q  <= '0;
      burst_q    <= '0;
      smp_cnt_q  <= '0;
      pending_q  <= 1'b0;
      inflight_q <= 1'b0;
      m_valid_o  <= 1'b0;
      m_data_o   <= '0;
      done_o     <= 1'b0;
      late_o     <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      done_o <= done_d;
      if (state_q == ST_STARTUP && !su_done) su_cnt_q <= su_cnt_q + SCW'(1);

      if (launch) begin
        mode_q    <= mode_i;
        period_q  <= (period_i == '0) ? PERIOD_WIDTH'(1) : period_i;
        burst_q   <= (burst_len_i == '0) ? (BCW'(1) << BURST_WIDTH) : BCW'(burst_len_i);
        per_cnt_q <= '0;
        smp_cnt_q <= '0;
        pending_q <= 1'b0;
        late_o    <= 1'b0;
        overrun_o <= 1'b0;
      end

      if (state_q == ST_RUN) begin
        per_cnt_q <= tick ? (period_q - PERIOD_WIDTH'(1)) : (per_cnt_q - PERIOD_WIDTH'(1));
        if (tick) begin
          if (pending_q) late_o    <= 1'b1;
          else           pending_q <= 1'b1;
        end
        if (adc_request_o || abort_i || burst_end) pending_q <= 1'b0;
      end

      if (adc_request_o) inflight_q <= 1'b1;
      else if (capture)  inflight_q <= 1'b0;

      if (capture) smp_cnt_q <= smp_cnt_q + BCW'(1);

      if (m_valid_o && m_ready_i) m_valid_o <= 1'b0;
      if (capture) begin
        if (can_load) begin
          m_data_o  <= adc_data_i;
          m_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end
    end
  end

`ifdef SAMPLE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt_q, ts_req_q, m_ts_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_cnt_q <= '0;
      ts_req_q <= '0;
      m_ts_q   <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_WIDTH'(1);
      if (adc_request_o)        ts_req_q <= ts_cnt_q;
      if (capture && can_load)  m_ts_q   <= ts_req_q;
    end
  end

  assign m_ts_o = m_ts_q;
`else
  assign m_ts_o = '0;
`endif

endmodule

// File: tb/tb_ad7476a_sample_scheduler.sv
module tb_ad7476a_sample_scheduler;
  localparam int DW   = 12;
  localparam int PW   = 16;
  localparam int BW   = 8;
  localparam int TW   = 32;
  localparam int CONV = 40;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0, abort_i = 1'b0, mode_i = 1'b0;
  logic [PW-1:0] period_i = '0;
  logic [BW-1:0] burst_len_i = '0;
  logic          adc_request_o;
  logic [DW-1:0] adc_data_i = '0;
  logic          adc_data_valid_i = 1'b0;
  logic          m_valid_o, m_ready_i = 1'b1;
  logic [DW-1:0] m_data_o;
  logic [TW-1:0] m_ts_o;
  logic          busy_o, done_o, late_o, overrun_o;

  ad7476a_sample_scheduler #(
    .NUM_DEVICES(1), .PERIOD_WIDTH(PW), .BURST_WIDTH(BW),
    .STARTUP_CYCLES(4), .TS_WIDTH(TW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .mode_i(mode_i), .period_i(period_i), .burst_len_i(burst_len_i),
    .adc_request_o(adc_request_o), .adc_data_i(adc_data_i),
    .adc_data_valid_i(adc_data_valid_i), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_ts_o(m_ts_o),
    .busy_o(busy_o), .done_o(done_o), .late_o(late_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ADC model: 40-cycle conversion, one-cycle data_valid, incrementing data.
  int            cd = 0;
  int            bad_req = 0;
  logic [DW-1:0] dnext = 12'h100;
  logic          sb_en = 1'b1;
  int            req_cyc[$];
  int            valid_cyc[$];
  logic [DW-1:0] data_hist[$];
  logic [DW-1:0] sb_q[$];

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      cd = 0;
      adc_data_valid_i = 1'b0;
    end else if (cd == 1) begin
      cd = 0;
      adc_data_valid_i = 1'b1;
      adc_data_i = dnext;
      data_hist.push_back(dnext);
      valid_cyc.push_back(cyc);
      if (sb_en) sb_q.push_back(dnext);
      dnext = dnext + 12'h011;
    end else begin
      adc_data_valid_i = 1'b0;
      if (cd > 0) cd--;
    end
    #1;
    if (rst_ni && adc_request_o) begin
      req_cyc.push_back(cyc);
      if (adc_data_valid_i || cd != 0) bad_req++;
      cd = CONV;
    end
  end

  // Stream monitor / scoreboard consumer.
  int            done_cnt = 0, done_cyc = 0, beats = 0;
  logic [TW-1:0] ts_hist[$];
  always @(negedge clk_i) begin
    #2;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (m_valid_o && m_ready_i) begin
      beats++;
      ts_hist.push_back(m_ts_o);
      if (sb_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
      else check("sb_data", 64'(m_data_o), 64'(sb_q.pop_front()));
    end
  end

  task automatic wait_done(input int n, input int budget, input string tag);
    int i;
    for (i = 0; i < budget && done_cnt < n; i++) begin
      @(negedge clk_i);
      #3;
    end
    if (done_cnt < n) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_req(input int n, input int budget, input string tag);
    int i;
    for (i = 0; i < budget && req_cyc.size() < n; i++) begin
      @(negedge clk_i);
      #3;
    end
    if (req_cyc.size() < n) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic pulse_start(input logic m, input int per, input int bl, output int s);
    @(negedge clk_i);
    mode_i = m; period_i = PW'(per); burst_len_i = BW'(bl);
    start_i = 1'b1;
    s = cyc;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
  endtask

  initial begin
    int s, r0, v0, b0, d0, h0;

    // Reset state
    repeat (3) @(negedge clk_i);
    #3;
    check("rst_outputs", 64'({adc_request_o, m_valid_o, m_data_o, busy_o, done_o, late_o, overrun_o}), 64'd0);
    check("rst_ts", 64'(m_ts_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    #3;
    check("startup_no_req", 64'(req_cyc.size()), 64'd0);
    check("idle_not_busy", 64'(busy_o), 64'd0);

    // 1: burst of 3, period 200
    r0 = req_cyc.size(); b0 = beats; d0 = done_cnt;
    pulse_start(1'b1, 200, 3, s);
    wait_done(d0 + 1, 1000, "t1_done");
    repeat (5) @(negedge clk_i);
    #3;
    check("t1_req_count", 64'(req_cyc.size() - r0), 64'd3);
    if (req_cyc.size() - r0 >= 3) begin
      check("t1_first_latency", 64'(req_cyc[r0] - s), 64'd2);
      check("t1_gap0", 64'(req_cyc[r0+1] - req_cyc[r0]), 64'd200);
      check("t1_gap1", 64'(req_cyc[r0+2] - req_cyc[r0+1]), 64'd200);
    end
    check("t1_beats", 64'(beats - b0), 64'd3);
    check("t1_done_once", 64'(done_cnt - d0), 64'd1);
    check("t1_busy", 64'(busy_o), 64'd0);
    check("t1_flags", 64'({late_o, overrun_o}), 64'd0);

    // start and abort together in IDLE: abort wins
    @(negedge clk_i);
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; abort_i = 1'b0;
    r0 = req_cyc.size();
    repeat (5) @(negedge clk_i);
    #3;
    check("sa_busy", 64'(busy_o), 64'd0);
    check("sa_no_req", 64'(req_cyc.size() - r0), 64'd0);

    // 2: continuous, period 10 -> late ticks, requests gated by data_valid
    r0 = req_cyc.size(); v0 = valid_cyc.size(); d0 = done_cnt;
    pulse_start(1'b0, 10, 0, s);
    wait_req(r0 + 5, 400, "t2_req");
    #3;
    check("t2_late", 64'(late_o), 64'd1);
    check("t2_req_in_valid", 64'(bad_req), 64'd0);
    for (int k = 1; k < 5; k++)
      check($sformatf("t2_req%0d_after_valid", k), 64'(req_cyc[r0+k]), 64'(valid_cyc[v0+k-1] + 1));
    pulse_abort();
    wait_done(d0 + 1, 100, "t2_done");
    #3;
    check("t2_busy", 64'(busy_o), 64'd0);
    check("t2_overrun", 64'(overrun_o), 64'd0);

    // 3: burst of 4 with consumer stalled
    sb_en = 1'b0;
    h0 = data_hist.size(); d0 = done_cnt;
    @(negedge clk_i);
    m_ready_i = 1'b0;
    pulse_start(1'b1, 60, 4, s);
    wait_done(d0 + 1, 600, "t3_done");
    #3;
    check("t3_overrun", 64'(overrun_o), 64'd1);
    check("t3_late", 64'(late_o), 64'd0);
    check("t3_valid_held", 64'(m_valid_o), 64'd1);
    check("t3_samples", 64'(data_hist.size() - h0), 64'd4);
    check("t3_data_first", 64'(m_data_o), 64'(data_hist[h0]));
    sb_q.push_back(data_hist[h0]);
    sb_en = 1'b1;
    @(negedge clk_i);
    m_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #3;
    check("t3_drained", 64'(m_valid_o), 64'd0);
    check("t3_sb_empty", 64'(sb_q.size()), 64'd0);

    // 4: continuous, abort mid-conversion
    r0 = req_cyc.size(); b0 = beats; d0 = done_cnt; v0 = valid_cyc.size();
    pulse_start(1'b0, 100, 0, s);
    wait_req(r0 + 1, 10, "t4_req");
    repeat (10) @(negedge clk_i);
    pulse_abort();
    #3;
    check("t4_drain_busy", 64'(busy_o), 64'd1);
    wait_done(d0 + 1, 100, "t4_done");
    repeat (150) @(negedge clk_i);
    #3;
    check("t4_no_new_req", 64'(req_cyc.size() - r0), 64'd1);
    check("t4_beats", 64'(beats - b0), 64'd1);
    if (valid_cyc.size() > v0)
      check("t4_done_timing", 64'(done_cyc), 64'(valid_cyc[v0] + 1));
    check("t4_idle", 64'(busy_o), 64'd0);

    // 5: reset mid-conversion, start right after release is ignored
    r0 = req_cyc.size();
    pulse_start(1'b0, 50, 0, s);
    wait_req(r0 + 1, 10, "t5_req");
    repeat (5) @(negedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check("t5_async_outputs", 64'({adc_request_o, m_valid_o, m_data_o, busy_o, done_o, late_o, overrun_o}), 64'd0);
    repeat (2) @(negedge clk_i);
    sb_q.delete();
    rst_ni = 1'b1;
    r0 = req_cyc.size();
    pulse_start(1'b0, 50, 0, s);
    repeat (20) @(negedge clk_i);
    #3;
    check("t5_no_req_after_rst", 64'(req_cyc.size() - r0), 64'd0);
    check("t5_busy", 64'(busy_o), 64'd0);
    d0 = done_cnt;
    pulse_start(1'b0, 50, 0, s);
    wait_req(r0 + 1, 5, "t5_restart");
    pulse_abort();
    wait_done(d0 + 1, 100, "t5_done");

`ifdef SAMPLE_TIMESTAMP_EN
    // 6: timestamps spaced by the period
    begin
      int t0;
      t0 = ts_hist.size(); d0 = done_cnt;
      pulse_start(1'b0, 100, 0, s);
      for (int i = 0; i < 600 && ts_hist.size() < t0 + 4; i++) @(negedge clk_i);
      #3;
      check("t6_beats", 64'(ts_hist.size() >= t0 + 4), 64'd1);
      if (ts_hist.size() >= t0 + 4)
        for (int k = 1; k < 4; k++)
          check($sformatf("t6_ts_gap%0d", k), 64'(ts_hist[t0+k] - ts_hist[t0+k-1]), 64'd100);
      pulse_abort();
      wait_done(d0 + 1, 200, "t6_done");
    end
`endif

    repeat (3) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
